// File: rtl/ram_cmd_master.sv
// Initiator for the 10-bit RAM command interface: turns host read/write requests into
// {op,byte} command words and collects read data. Define RAM_CMD_ADDR_CACHE_EN to skip repeated address words.
module ram_cmd_master #(
    parameter int ADDR_SIZE = 8,
    parameter int TIMEOUT   = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_wr,
    input  logic [ADDR_SIZE-1:0] req_addr,
    input  logic [7:0]           req_wdata,
    output logic                 rsp_valid,
    output logic [7:0]           rsp_data,
    output logic                 rsp_err,
    output logic [9:0]           ram_din,
    output logic                 ram_rx_valid,
    input  logic [7:0]           ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 busy
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WDATA, S_RADDR, S_RDCMD, S_WAIT, S_RESP
    } state_t;

    state_t        state, next_state;
    logic [7:0]    addr_ext;
    logic [7:0]    cap_addr;
    logic [7:0]    cap_wdata;
    logic [CW-1:0] cnt;
    logic [7:0]    rd_data;
    logic          rd_err;
    logic          wr_hit, rd_hit;
    logic          accept;

    always_comb begin
        addr_ext = '0;
        addr_ext[ADDR_SIZE-1:0] = req_addr;
    end

`ifdef RAM_CMD_ADDR_CACHE_EN
    logic       wc_valid, rc_valid;
    logic [7:0] wc_addr, rc_addr;

    assign wr_hit = wc_valid && (wc_addr == addr_ext);
    assign rd_hit = rc_valid && (rc_addr == addr_ext);

    // Flags are set in the same cycle the address word is registered onto ram_din.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wc_valid <= 1'b0;
            rc_valid <= 1'b0;
            wc_addr  <= '0;
            rc_addr  <= '0;
        end else begin
            if (state == S_WADDR) begin
                wc_valid <= 1'b1;
                wc_addr  <= cap_addr;
            end
            if (state == S_RADDR) begin
                rc_valid <= 1'b1;
                rc_addr  <= cap_addr;
            end
        end
    end
`else
    assign wr_hit = 1'b0;
    assign rd_hit = 1'b0;
`endif

    assign req_ready = (state == S_IDLE) && !rst;
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && req_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_wr) next_state = wr_hit ? S_WDATA : S_WADDR;
                    else        next_state = rd_hit ? S_RDCMD : S_RADDR;
                end
            end
            S_WADDR: next_state = S_WDATA;
            S_WDATA: next_state = S_RESP;
            S_RADDR: next_state = S_RDCMD;
            S_RDCMD: next_state = S_WAIT;
            S_WAIT:  if (ram_tx_valid || cnt == TMO) next_state = S_RESP;
            S_RESP:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the current state, so each lags its state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cnt          <= '0;
            rd_data      <= '0;
            rd_err       <= 1'b0;
            ram_din      <= '0;
            ram_rx_valid <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
        end else begin
            if (accept) begin
                cap_addr  <= addr_ext;
                cap_wdata <= req_wdata;
                rd_data   <= '0;
                rd_err    <= 1'b0;
            end

            case (state)
                S_WADDR: begin ram_din <= {2'b00, cap_addr};  ram_rx_valid <= 1'b1; end
                S_WDATA: begin ram_din <= {2'b01, cap_wdata}; ram_rx_valid <= 1'b1; end
                S_RADDR: begin ram_din <= {2'b10, cap_addr};  ram_rx_valid <= 1'b1; end
                S_RDCMD: begin ram_din <= {2'b11, 8'h00};     ram_rx_valid <= 1'b1; end
                default: begin ram_din <= '0;                 ram_rx_valid <= 1'b0; end
            endcase

            if (state == S_RDCMD) begin
                cnt <= '0;
            end else if (state == S_WAIT) begin
                cnt <= cnt + CW'(1);
                if (ram_tx_valid) begin
                    rd_data <= ram_dout;
                    rd_err  <= 1'b0;
                end else if (cnt == TMO) begin
                    rd_data <= '0;
                    rd_err  <= 1'b1;
                end
            end

            rsp_valid <= (state == S_RESP);
            rsp_data  <= (state == S_RESP) ? rd_data : '0;
            rsp_err   <= (state == S_RESP) && rd_err;
        end
    end
endmodule

// File: tb/tb_ram_cmd_master.sv
// Self-checking bench for ram_cmd_master: drives host requests, acts as the RAM responder,
// and compares command words, latency and responses against a transaction-level model.
module tb_ram_cmd_master;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_wr = 1'b0;
    logic [7:0] req_addr = '0;
    logic [7:0] req_wdata = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [256];
    bit         wc_v, rc_v;
    logic [7:0] wc_a, rc_a;

    always #5 clk = ~clk;

    ram_cmd_master #(.ADDR_SIZE(8), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
        .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid), .busy(busy)
    );

    // One request: d = RAM answer delay in WAIT cycles (d > TMO never answers).
    task automatic txn(input bit wr, input logic [7:0] addr, input logic [7:0] wdata,
                       input int d, input bit spur);
        logic [9:0] words[$];
        logic [9:0] exp_words[$];
        int         kc = -1;
        int         krsp = -1;
        int         wt = 0;
        bit         hit = 0;
        int         exp_k;
        logic [7:0] exp_data;
        bit         exp_err;

        @(negedge clk);
        while (!req_ready && wt < 100) begin @(negedge clk); wt++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait: req_ready=%b required 1", req_ready);
            return;
        end

`ifdef RAM_CMD_ADDR_CACHE_EN
        hit = wr ? (wc_v && wc_a == addr) : (rc_v && rc_a == addr);
`endif
        if (!hit) exp_words.push_back({wr ? 2'b00 : 2'b10, addr});
        exp_words.push_back(wr ? {2'b01, wdata} : 10'h300);
        if (wr) begin
            exp_k = 4 - int'(hit); exp_data = 8'h00; exp_err = 0;
        end else if (d <= TMO) begin
            exp_k = 5 - int'(hit) + d; exp_data = mem[addr]; exp_err = 0;
        end else begin
            exp_k = 5 - int'(hit) + TMO; exp_data = 8'h00; exp_err = 1;
        end

        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        if (spur) begin ram_tx_valid = 1'b1; ram_dout = 8'($urandom); end

        for (int k = 1; k <= 60 && krsp < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid = 1'b0;
                req_wr = 1'($urandom); req_addr = 8'($urandom); req_wdata = 8'($urandom);
            end
            ram_tx_valid = spur && (k == 1);
            if (ram_rx_valid) begin
                words.push_back(ram_din);
                if (ram_din[9:8] == 2'b11) kc = k;
            end
            if (rsp_valid) begin
                krsp = k;
                checks++;
                if (rsp_data !== exp_data) begin
                    errors++;
                    $display("FAIL rsp_data: addr=%h got %h required %h", addr, rsp_data, exp_data);
                end
                checks++;
                if (rsp_err !== exp_err) begin
                    errors++;
                    $display("FAIL rsp_err: addr=%h got %b required %b", addr, rsp_err, exp_err);
                end
                checks++;
                if (req_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_after_rsp: got %b required 1", req_ready);
                end
            end
            if (!wr && kc >= 0 && k == kc + d) begin
                ram_tx_valid = 1'b1;
                ram_dout = mem[addr];
            end
        end
        ram_tx_valid = 1'b0;

        checks++;
        if (krsp != exp_k) begin
            errors++;
            $display("FAIL latency: wr=%b addr=%h got %0d cycles required %0d", wr, addr, krsp - 1, exp_k - 1);
        end
        checks++;
        if (words.size() != exp_words.size()) begin
            errors++;
            $display("FAIL word_count: got %0d required %0d", words.size(), exp_words.size());
        end else begin
            foreach (exp_words[i]) begin
                checks++;
                if (words[i] !== exp_words[i]) begin
                    errors++;
                    $display("FAIL word%0d: got %h required %h", i, words[i], exp_words[i]);
                end
            end
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rsp_pulse: rsp_valid=%b required 0", rsp_valid);
        end

        if (wr) begin mem[addr] = wdata; wc_v = 1; wc_a = addr; end
        else    begin rc_v = 1; rc_a = addr; end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({ram_din, ram_rx_valid, rsp_valid, rsp_data, rsp_err, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: din=%h rxv=%b rspv=%b data=%h err=%b busy=%b ready=%b required all 0",
                     ram_din, ram_rx_valid, rsp_valid, rsp_data, rsp_err, busy, req_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b required 1/0", req_ready, busy);
        end
    endtask

    task automatic test_write();
        txn(1, 8'h12, 8'h3C, 0, 0);
    endtask

    task automatic test_read();
        txn(0, 8'h12, 8'h00, 0, 0);
        checks++;
        if (mem[8'h12] !== 8'h3C) begin
            errors++;
            $display("FAIL model_mem: got %h required 3c", mem[8'h12]);
        end
    endtask

    task automatic test_timeout();
        txn(0, 8'h21, 8'h00, TMO + 10, 0);
        txn(0, 8'h22, 8'h00, TMO, 0);
        txn(0, 8'h23, 8'h00, TMO + 1, 0);
    endtask

    task automatic test_abort();
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 8'h5A; req_wdata = 8'h00;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({ram_din, ram_rx_valid, rsp_valid, rsp_data, rsp_err, busy, req_ready} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: din=%h rxv=%b rspv=%b busy=%b ready=%b required all 0",
                     ram_din, ram_rx_valid, rsp_valid, busy, req_ready);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_rsp: rsp_valid=%b required 0", rsp_valid);
            end
        end
        rst = 1'b0;
        wc_v = 0; rc_v = 0;
        txn(0, 8'h5A, 8'h00, 1, 0);
    endtask

    task automatic test_back_to_back();
        txn(1, 8'h40, 8'hAA, 0, 0);
        txn(1, 8'h40, 8'h55, 0, 0);
        txn(0, 8'h40, 8'h00, 2, 0);
    endtask

    task automatic test_spurious();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ram_tx_valid = 1'b1; ram_dout = 8'($urandom);
            checks++;
            if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL spurious_idle: rsp_valid=%b busy=%b required 0/0", rsp_valid, busy);
            end
        end
        ram_tx_valid = 1'b0;
        txn(1, 8'h66, 8'h99, 0, 1);
        txn(0, 8'h66, 8'h00, 0, 1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            bit         wr = 1'($urandom);
            logic [7:0] a = 8'($urandom_range(0, 3)) + 8'h80;
            int         d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO + 2) : $urandom_range(0, 2);
            txn(wr, a, 8'($urandom), d, 1'($urandom));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        wc_v = 0; rc_v = 0; wc_a = '0; rc_a = '0;
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_abort();
        test_back_to_back();
        test_spurious();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
